// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared command FSM states and default-limit helper for clkdiv_multi
package clkdiv_pkg;

    typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;

    function automatic longint unsigned def_limit(input longint unsigned clk_hz, input longint unsigned def_hz);
        longint unsigned q;
        q = clk_hz / (2 * def_hz);
        return (q == 64'd0) ? 64'd0 : q - 64'd1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider producing one quotient bit per cycle after a start pulse
module seq_divider #(
    parameter int DW = 32,
    parameter int VW = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic          done_o,
    output logic [DW-1:0] quotient_o
);
    localparam int SW = (DW > 1) ? $clog2(DW) : 1;

    logic [VW-1:0] rem_q, rem_d, div_q;
    logic [DW-1:0] quo_q, quo_d;
    logic [SW-1:0] step_q;
    logic          busy_q;
    logic [VW:0]   sh;
    logic          ge;

    // trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        sh    = {rem_q, quo_q[DW-1]};
        ge    = sh >= {1'b0, div_q};
        rem_d = ge ? VW'(sh - {1'b0, div_q}) : sh[VW-1:0];
        quo_d = {quo_q[DW-2:0], ge};
    end

    assign done_o     = busy_q && (step_q == SW'(DW - 1));
    assign quotient_o = quo_q;

    // load operands on start, then iterate DW steps
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            div_q  <= divisor_i;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            step_q <= step_q + SW'(1);
            busy_q <= !done_o;
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH run-time programmable square-wave/strobe generators sharing one divider
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int          NCH    = 4,
    parameter int          CW     = 32,
    parameter int          CNT_W  = 32,
    parameter int unsigned DEF_HZ = 1,
    localparam int         CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           iClk50M,
    input  logic           iRst,
    input  logic           iCmdValid,
    output logic           oCmdReady,
    input  logic [CHW-1:0] iCmdCh,
    input  logic [CW-1:0]  iCmdHz,
    input  logic [NCH-1:0] iEn,
    output logic [NCH-1:0] oClk,
    output logic [NCH-1:0] oTick
);
    localparam logic [CNT_W-1:0] DEF_LIM  = CNT_W'(def_limit(64'(CLK_HZ), 64'(DEF_HZ)));
    localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ);

    state_t         state_q;
    logic [CHW-1:0] ch_q;
    logic           zero_q;
    logic           ready_q;
    logic           accept;
    logic           div_done;
    logic [CNT_W-1:0] quo;
    logic [CNT_W-1:0] new_lim;
    logic           commit_wr;

    assign accept    = iCmdValid && ready_q;
    assign oCmdReady = ready_q;
    assign new_lim   = (quo == '0) ? '0 : quo - CNT_W'(1);
    assign commit_wr = (state_q == COMMIT) && (32'(ch_q) < 32'(NCH));

    seq_divider #(.DW(CNT_W), .VW(CW + 1)) u_div (
        .clk        (iClk50M),
        .rst        (iRst),
        .start_i    (accept && (iCmdHz != '0)),
        .dividend_i (DIVIDEND),
        .divisor_i  ({iCmdHz, 1'b0}),
        .done_o     (div_done),
        .quotient_o (quo)
    );

    // command sequencing: accept, divide (skipped for stop), commit
    always_ff @(posedge iClk50M) begin
        if (iRst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            ch_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    ch_q    <= iCmdCh;
                    zero_q  <= (iCmdHz == '0);
                    state_q <= (iCmdHz == '0) ? COMMIT : DIV;
                    ready_q <= 1'b0;
                end
                DIV: if (div_done) state_q <= COMMIT;
                COMMIT: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, lim_q, pend_q;
        logic             pflag_q, stop_q, clk_q, tick_q;
        logic             wr, run;

        assign wr       = commit_wr && (ch_q == CHW'(i));
        assign run      = iEn[i] && !stop_q;
        assign oClk[i]  = clk_q;
        assign oTick[i] = tick_q;

        // half-period counter; settings swap only at a toggle unless the channel is idle
        always_ff @(posedge iClk50M) begin
            if (iRst) begin
                cnt_q   <= '0;
                lim_q   <= DEF_LIM;
                pend_q  <= '0;
                pflag_q <= 1'b0;
                stop_q  <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (!iEn[i]) begin
                    cnt_q <= '0;
                    clk_q <= 1'b0;
                end else if (!stop_q) begin
                    if (cnt_q == lim_q) begin
                        cnt_q  <= '0;
                        clk_q  <= ~clk_q;
                        tick_q <= ~clk_q;
                        if (pflag_q) begin
                            lim_q   <= pend_q;
                            pflag_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                if (wr && zero_q) begin
                    stop_q  <= 1'b1;
                    cnt_q   <= '0;
                    clk_q   <= 1'b0;
                    tick_q  <= 1'b0;
                    pflag_q <= 1'b0;
                end else if (wr && run) begin
                    pend_q  <= new_lim;
                    pflag_q <= 1'b1;
                end else if (wr) begin
                    lim_q   <= new_lim;
                    stop_q  <= 1'b0;
                    cnt_q   <= '0;
                    pflag_q <= 1'b0;
                end
            end
        end
    end

endmodule
